// File: rtl/serial_chunk_adder_if.sv
`default_nettype none
// ============================================================================
// Module      : serial_chunk_adder_if
// Description : Request/result bundle for serial_chunk_adder. The master side
//               issues a start with operands; the slave side returns the sum,
//               carry-out and the busy/done status.
//               Optional macro ADDER_OVF_EN adds the signed-overflow flag ovf.
// Revision    : 1.0 - initial release
// ============================================================================
interface serial_chunk_adder_if #(
  parameter int WIDTH = 16
) ();

  logic             start;
  logic             sub;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             busy;
  logic             done;
`ifdef ADDER_OVF_EN
  logic             ovf;

  modport master (
    output start, sub, a, b, cin,
    input  sum, cout, busy, done, ovf
  );

  modport slave (
    input  start, sub, a, b, cin,
    output sum, cout, busy, done, ovf
  );
`else
  modport master (
    output start, sub, a, b, cin,
    input  sum, cout, busy, done
  );

  modport slave (
    input  start, sub, a, b, cin,
    output sum, cout, busy, done
  );
`endif

endinterface : serial_chunk_adder_if
`default_nettype wire

// File: rtl/serial_chunk_adder.sv
`default_nettype none
// ============================================================================
// Module      : serial_chunk_adder
// Description : Multi-cycle adder/subtractor. Operands are captured on start
//               and added CHUNK bits per clock, least significant chunk first,
//               with the inter-chunk carry held in a register. A one-cycle
//               done pulse marks a valid result; sum/cout hold until the next
//               accepted start.
//               Optional macro ADDER_OVF_EN adds a signed-overflow output.
// Revision    : 1.0 - initial release
// ============================================================================
module serial_chunk_adder #(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  serial_chunk_adder_if.slave  bus
);

  localparam int N     = WIDTH / CHUNK;
  localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(N - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t             state_q;
  logic [WIDTH-1:0]   a_q;
  logic [WIDTH-1:0]   b_q;        // already inverted for subtraction
  logic               carry_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [WIDTH-1:0]   sum_q;
  logic               cout_q;
  logic               busy_q;
  logic               done_q;

  // Current chunk slice and its partial sum
  logic [CHUNK-1:0]   chunk_a;
  logic [CHUNK-1:0]   chunk_b;
  logic [CHUNK-1:0]   chunk_sum_d;
  logic               carry_d;

  // Select the active chunk and add it with the registered carry only, so no
  // carry path ever spans two chunks combinationally
  always_comb begin
    chunk_a = a_q[cnt_q*CHUNK +: CHUNK];
    chunk_b = b_q[cnt_q*CHUNK +: CHUNK];
    {carry_d, chunk_sum_d} = {1'b0, chunk_a} + {1'b0, chunk_b}
                           + {{CHUNK{1'b0}}, carry_q};
  end

`ifdef ADDER_OVF_EN
  logic ovf_q;
  logic msb_cin;      // carry into the top bit of the current chunk
  logic ovf_d;

  generate
    if (CHUNK == 1) begin : g_msb_single
      assign msb_cin = carry_q;
    end else begin : g_msb_multi
      logic [CHUNK-1:0] low_sum;
      assign low_sum = {1'b0, chunk_a[CHUNK-2:0]}
                     + {1'b0, chunk_b[CHUNK-2:0]}
                     + {{(CHUNK-1){1'b0}}, carry_q};
      assign msb_cin = low_sum[CHUNK-1];
    end
  endgenerate

  // Signed overflow is meaningful only on the last chunk, where the top bit of
  // the chunk is bit WIDTH-1 of the result
  assign ovf_d = msb_cin ^ carry_d;
`endif

  // Control FSM with all datapath registers and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef ADDER_OVF_EN
      ovf_q   <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.start) begin
            // Subtraction is a + ~b + 1, so the carry-in is forced high
            a_q     <= bus.a;
            b_q     <= bus.b ^ {WIDTH{bus.sub}};
            carry_q <= bus.sub ? 1'b1 : bus.cin;
            cnt_q   <= '0;
            sum_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= RUN;
          end
        end

        RUN: begin
          sum_q[cnt_q*CHUNK +: CHUNK] <= chunk_sum_d;
          carry_q <= carry_d;
          if (cnt_q == LAST_CNT) begin
            cnt_q   <= '0;
            cout_q  <= carry_d;
`ifdef ADDER_OVF_EN
            ovf_q   <= ovf_d;
`endif
            done_q  <= 1'b1;
            state_q <= DONE;
          end else begin
            cnt_q   <= cnt_q + 1'b1;
          end
        end

        DONE: begin
          // Start is not sampled here; back-to-back requests land in IDLE
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end

        default: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign bus.sum  = sum_q;
  assign bus.cout = cout_q;
  assign bus.busy = busy_q;
  assign bus.done = done_q;
`ifdef ADDER_OVF_EN
  assign bus.ovf  = ovf_q;
`endif

endmodule : serial_chunk_adder
`default_nettype wire
